imm_gen_pipe: RTL

//  Registered, parametrised immediate generator for the decode stage.
//  - Accepts full 32-bit instructions over a valid/ready handshake.
//  - Decodes the format from the opcode; emits one XLEN-wide sign-extended immediate plus a format code.
//  - Holds results in a 2-entry skid buffer: full throughput under backpressure, no combinational ready path.

---
 rtl/imm_gen_pkg.sv | 38 +++
 rtl/imm_decode.sv | 69 ++++++
 rtl/imm_gen_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the imm_gen_pipe immediate generator.
// The IMM_GEN_ZICSR_EN macro (used by imm_decode) enables the Z format for SYSTEM opcodes.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] SYSTEM = 7'h73;

    // Decoder result before the sideband tag is attached.
    typedef struct packed {
        imm_fmt_e fmt;
        logic     ill;
    } dec_info_t;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational instruction -> {imm, fmt, ill} decoder, XLEN = 32 or 64.
// Define IMM_GEN_ZICSR_EN to decode SYSTEM CSR instructions as format Z.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm,
    output dec_info_t       info
);

    logic [6:0]  opcode;
    logic [31:0] imm32;

    assign opcode = ir[6:0];

    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
        imm32     = '0;
        info.fmt  = FMT_NONE;
        info.ill  = 1'b0;
        case (opcode)
            OP_IMM, LOAD, JALR: begin
                info.fmt = FMT_I;
                imm32    = {{20{ir[31]}}, ir[31:20]};
            end
            STORE: begin
                info.fmt = FMT_S;
                imm32    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            BRANCH: begin
                info.fmt = FMT_B;
                imm32    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                info.fmt = FMT_U;
                imm32    = {ir[31:12], 12'b0};
            end
            JAL: begin
                info.fmt = FMT_J;
                imm32    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP: begin
                info.fmt = FMT_NONE;
            end
`ifdef IMM_GEN_ZICSR_EN
            SYSTEM: begin
                // funct3==0 is ECALL/EBREAK/xRET: legal but carries no immediate.
                if (ir[14:12] != 3'b000) begin
                    info.fmt = FMT_Z;
                    imm32    = ir[14] ? {27'b0, ir[19:15]} : {20'b0, ir[31:20]};
                end
            end
`endif
            default: begin
                info.ill = 1'b1;
            end
        endcase
    end

    // Z-format values keep bit 31 clear, so sign extension leaves them zero-extended.
    if (XLEN == 64) begin : g_xlen64
        assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_xlen32
        assign imm = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: imm_decode followed by a 2-entry skid buffer with registered in_ready.
// Optional CSR decode is enabled with the IMM_GEN_ZICSR_EN macro.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_ill,
    output logic [TAG_W-1:0] out_tag
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64, got %0d", XLEN);
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    dec_info_t       dec_info;
    entry_t          in_entry;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .ir   (in_ir),
        .imm  (dec_imm),
        .info (dec_info)
    );

    assign in_entry = '{imm: dec_imm, fmt: dec_info.fmt, ill: dec_info.ill, tag: in_tag};

    buf_state_e state_q, state_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    logic       in_ready_q, in_ready_d;
    logic       in_fire, out_fire;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_entry;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_entry;
                end else if (in_fire) begin
                    skid_d  = in_entry;
                    state_d = BUF_FULL;
                end else if (out_fire) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        // Ready is computed from the next state and registered: no in->out combinational path.
        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload registers are reset as well, because the outputs must read zero in reset.
            state_q    <= BUF_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment only; the _d values come from the always_comb above.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_imm = main_q.imm;
    assign out_fmt = main_q.fmt;
    assign out_ill = main_q.ill;
    assign out_tag = main_q.tag;

endmodule
